// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera register-table configuration sequencer.
package cam_cfg_pkg;

   localparam int unsigned ENTRY_W = 16;

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      DECODE,
      ISSUE,
      WAIT_WR,
      GAP,
      DELAY,
      DONE,
      ERROR
   } state_e;

   typedef struct packed {
      logic [7:0] reg_addr;
      logic [7:0] val;
   } entry_t;

   localparam logic [ENTRY_W-1:0] END_MARK  = 16'hFFFF;
   localparam logic [7:0]         DELAY_TAG = 8'hFE;

endpackage

// File: rtl/cam_reg_rom.sv
// Register table: synchronous one-cycle-latency ROM of {reg, val} entries, entry 0 in the LSBs of ROM_INIT.
module cam_reg_rom
   import cam_cfg_pkg::*;
#(
   parameter int unsigned                     TABLE_LEN = 128,
   parameter int unsigned                     IDX_W     = $clog2(TABLE_LEN),
   parameter logic [TABLE_LEN*ENTRY_W-1:0]    ROM_INIT  = '1
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             rd_en_i,
   input  logic [IDX_W-1:0] addr_i,
   output entry_t           data_o
);

   entry_t data_q;

   // Out-of-range addresses read as the end marker so a bad index stops the run.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         data_q <= '0;
      end else if (rd_en_i) begin
         if (int'(addr_i) < TABLE_LEN) begin
            data_q <= entry_t'(ROM_INIT[int'(addr_i)*ENTRY_W +: ENTRY_W]);
         end else begin
            data_q <= entry_t'(END_MARK);
         end
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/cam_config_seq.sv
// Walks the register table, issuing SCCB writes with retry/timeout and millisecond delay entries.
module cam_config_seq
   import cam_cfg_pkg::*;
#(
   parameter int unsigned                  TABLE_LEN   = 128,
   parameter int unsigned                  CYC_PER_MS  = 100_000,
   parameter int unsigned                  GAP_CYC     = 1000,
   parameter int unsigned                  TIMEOUT_CYC = 200_000,
   parameter int unsigned                  RETRY_MAX   = 3,
   parameter logic [TABLE_LEN*ENTRY_W-1:0] ROM_INIT    = '1
) (
   input  logic                         Clk,
   input  logic                         reset,
   input  logic                         start,
   output logic                         wr_req,
   output logic [7:0]                   wr_reg,
   output logic [7:0]                   wr_val,
   input  logic                         wr_done,
   input  logic                         wr_nack,
   output logic                         busy,
   output logic                         done,
   output logic                         error,
   output logic [$clog2(TABLE_LEN)-1:0] err_idx
);

   localparam int unsigned IDX_W    = $clog2(TABLE_LEN);
   localparam int unsigned RT_W     = $clog2(RETRY_MAX + 1);
   localparam int unsigned MAX_A    = (TIMEOUT_CYC > CYC_PER_MS) ? TIMEOUT_CYC : CYC_PER_MS;
   localparam int unsigned CNT_MAX  = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
   localparam int unsigned TO_LAST  = (TIMEOUT_CYC > 1) ? TIMEOUT_CYC - 1 : 0;
   localparam int unsigned MS_LAST  = (CYC_PER_MS > 1) ? CYC_PER_MS - 1 : 0;
   localparam int unsigned GAP_LAST = (GAP_CYC > 1) ? GAP_CYC - 1 : 0;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [RT_W-1:0]  retry_q, retry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       ms_q, ms_d;
   logic             start_prev_q;
   logic             wr_req_q, wr_req_d;
   logic [7:0]       wr_reg_q, wr_reg_d;
   logic [7:0]       wr_val_q, wr_val_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic [IDX_W-1:0] err_idx_q, err_idx_d;

   logic             start_rise_c;
   logic             last_c;
   logic             rom_en_c;
   logic [RT_W-1:0]  retry_nxt_c;
   entry_t           rom_data;

   cam_reg_rom #(
      .TABLE_LEN (TABLE_LEN),
      .IDX_W     (IDX_W),
      .ROM_INIT  (ROM_INIT)
   ) u_rom (
      .Clk     (Clk),
      .reset   (reset),
      .rd_en_i (rom_en_c),
      .addr_i  (idx_q),
      .data_o  (rom_data)
   );

   assign start_rise_c = start & ~start_prev_q;
   assign last_c       = (idx_q == IDX_W'(TABLE_LEN - 1));
   assign retry_nxt_c  = retry_q + RT_W'(1);

   // One counter serves as write timeout, inter-write gap and millisecond prescaler.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      retry_d   = retry_q;
      cnt_d     = '0;
      ms_d      = ms_q;
      wr_req_d  = wr_req_q;
      wr_reg_d  = wr_reg_q;
      wr_val_d  = wr_val_q;
      err_idx_d = err_idx_q;
      rom_en_c  = 1'b0;

      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start_rise_c) begin
               state_d = FETCH;
               idx_d   = '0;
               retry_d = '0;
            end
         end
         FETCH: begin
            rom_en_c = 1'b1;
            state_d  = DECODE;
         end
         DECODE: begin
            if (rom_data == entry_t'(END_MARK)) begin
               state_d = DONE;
            end else if (rom_data.reg_addr == DELAY_TAG) begin
               if (rom_data.val == 8'd0) begin
                  if (last_c) begin
                     state_d = DONE;
                  end else begin
                     idx_d   = idx_q + IDX_W'(1);
                     state_d = FETCH;
                  end
               end else begin
                  ms_d    = rom_data.val;
                  state_d = DELAY;
               end
            end else begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            wr_req_d = 1'b1;
            wr_reg_d = rom_data.reg_addr;
            wr_val_d = rom_data.val;
            state_d  = WAIT_WR;
         end
         WAIT_WR: begin
            // A simultaneous done and nack is a failed write.
            if (wr_nack || (cnt_q == CNT_W'(TO_LAST))) begin
               wr_req_d = 1'b0;
               retry_d  = retry_nxt_c;
               if (retry_nxt_c < RT_W'(RETRY_MAX)) begin
                  state_d = GAP;
               end else begin
                  err_idx_d = idx_q;
                  state_d   = ERROR;
               end
            end else if (wr_done) begin
               wr_req_d = 1'b0;
               retry_d  = '0;
               if (last_c) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = GAP;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt_q == CNT_W'(GAP_LAST)) begin
               state_d = FETCH;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DELAY: begin
            if (cnt_q == CNT_W'(MS_LAST)) begin
               if (ms_q == 8'd1) begin
                  if (last_c) begin
                     state_d = DONE;
                  end else begin
                     idx_d   = idx_q + IDX_W'(1);
                     state_d = FETCH;
                  end
               end else begin
                  ms_d = ms_q - 8'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d  = !((state_d == IDLE) || (state_d == DONE) || (state_d == ERROR));
      done_d  = (state_d == DONE);
      error_d = (state_d == ERROR);
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         retry_q      <= '0;
         cnt_q        <= '0;
         ms_q         <= '0;
         start_prev_q <= 1'b1;
         wr_req_q     <= 1'b0;
         wr_reg_q     <= '0;
         wr_val_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         err_idx_q    <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         retry_q      <= retry_d;
         cnt_q        <= cnt_d;
         ms_q         <= ms_d;
         start_prev_q <= start;
         wr_req_q     <= wr_req_d;
         wr_reg_q     <= wr_reg_d;
         wr_val_q     <= wr_val_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         err_idx_q    <= err_idx_d;
      end
   end

   assign wr_req  = wr_req_q;
   assign wr_reg  = wr_reg_q;
   assign wr_val  = wr_val_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign error   = error_q;
   assign err_idx = err_idx_q;

endmodule

// File: tb/tb_cam_config_seq.sv
// Directed bench: nominal run, nack retry, timeout, ignored start, reset mid-write, table without end marker.
module tb_cam_config_seq;

   localparam int ACK = 0, NACK = 1, SILENT = 2;

   logic       clk, rst;
   logic       start_a, start_b;
   logic       wr_req_a, wr_done_a, wr_nack_a, busy_a, done_a, error_a;
   logic [7:0] wr_reg_a, wr_val_a;
   logic [1:0] err_idx_a;
   logic       wr_req_b, wr_done_b, wr_nack_b, busy_b, done_b, error_b;
   logic [7:0] wr_reg_b, wr_val_b;
   logic [1:0] err_idx_b;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          mode = ACK;
   logic [15:0] log_a[$];
   int          rise_a[$];
   int          last_hi_a = 0;
   logic [15:0] log_b[$];

   cam_config_seq #(
      .TABLE_LEN(4), .CYC_PER_MS(10), .GAP_CYC(4), .TIMEOUT_CYC(50), .RETRY_MAX(3),
      .ROM_INIT({16'hFFFF, 16'h1101, 16'hFE02, 16'h1280})
   ) u_dut (
      .Clk(clk), .reset(rst), .start(start_a),
      .wr_req(wr_req_a), .wr_reg(wr_reg_a), .wr_val(wr_val_a),
      .wr_done(wr_done_a), .wr_nack(wr_nack_a),
      .busy(busy_a), .done(done_a), .error(error_a), .err_idx(err_idx_a)
   );

   cam_config_seq #(
      .TABLE_LEN(4), .CYC_PER_MS(10), .GAP_CYC(4), .TIMEOUT_CYC(50), .RETRY_MAX(3),
      .ROM_INIT({16'h0444, 16'h0333, 16'h0222, 16'h0111})
   ) u_dut_ne (
      .Clk(clk), .reset(rst), .start(start_b),
      .wr_req(wr_req_b), .wr_reg(wr_reg_b), .wr_val(wr_val_b),
      .wr_done(wr_done_b), .wr_nack(wr_nack_b),
      .busy(busy_b), .done(done_b), .error(error_b), .err_idx(err_idx_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Engine model for the main DUT: responds on the 5th cycle of a request per mode.
   initial begin
      int   hi_cnt = 0;
      logic sent   = 1'b0;
      logic prev   = 1'b0;
      wr_done_a = 1'b0;
      wr_nack_a = 1'b0;
      forever begin
         @(negedge clk);
         wr_done_a = 1'b0;
         wr_nack_a = 1'b0;
         if (wr_req_a) begin
            if (!prev) begin
               log_a.push_back({wr_reg_a, wr_val_a});
               rise_a.push_back(cyc);
            end
            hi_cnt++;
            if (!sent && mode != SILENT && hi_cnt == 5) begin
               if (mode == ACK) wr_done_a = 1'b1;
               else             wr_nack_a = 1'b1;
               sent = 1'b1;
            end
         end else begin
            if (hi_cnt != 0) last_hi_a = hi_cnt;
            hi_cnt = 0;
            sent   = 1'b0;
         end
         prev = wr_req_a;
      end
   end

   // Engine model for the no-end-marker DUT: always acks on the 2nd cycle.
   initial begin
      int   hi_cnt = 0;
      logic prev   = 1'b0;
      wr_done_b = 1'b0;
      wr_nack_b = 1'b0;
      forever begin
         @(negedge clk);
         wr_done_b = 1'b0;
         if (wr_req_b) begin
            if (!prev) log_b.push_back({wr_reg_b, wr_val_b});
            hi_cnt++;
            if (hi_cnt == 2) wr_done_b = 1'b1;
         end else begin
            hi_cnt = 0;
         end
         prev = wr_req_b;
      end
   end

   task automatic pulse_start(input bit sel_b);
      @(negedge clk);
      if (sel_b) start_b = 1'b1;
      else       start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_end(input string tag, input bit sel_b, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (sel_b ? (done_b | error_b) : (done_a | error_a)) break;
      end
      chk(tag, 32'(sel_b ? (done_b | error_b) : (done_a | error_a)), 32'd1);
   endtask

   task automatic wait_req(input logic lvl, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (wr_req_a == lvl) break;
         @(negedge clk);
      end
      chk("wait_req", 32'(wr_req_a), 32'(lvl));
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      int sp;
      rst = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_wr_req",  32'(wr_req_a),  32'd0);
      chk("rst_wr_reg",  32'(wr_reg_a),  32'd0);
      chk("rst_busy",    32'(busy_a),    32'd0);
      chk("rst_done",    32'(done_a),    32'd0);
      chk("rst_error",   32'(error_a),   32'd0);
      chk("rst_err_idx", 32'(err_idx_a), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Nominal: write 12=80, 2 ms delay, write 11=01, end marker.
      mode = ACK;
      pulse_start(1'b0);
      chk("nom_busy", 32'(busy_a), 32'd1);
      wait_end("nom_end", 1'b0, 2000);
      chk("nom_nwr",  32'(log_a.size()), 32'd2);
      chk("nom_wr0",  32'((log_a.size() > 0) ? log_a[0] : 16'h0), 32'h1280);
      chk("nom_wr1",  32'((log_a.size() > 1) ? log_a[1] : 16'h0), 32'h1101);
      sp = (rise_a.size() > 1) ? rise_a[1] - rise_a[0] : 0;
      chk("nom_spacing", 32'(sp >= 33 && sp <= 35), 32'd1);
      chk("nom_done",  32'(done_a),  32'd1);
      chk("nom_busy0", 32'(busy_a),  32'd0);
      chk("nom_error", 32'(error_a), 32'd0);

      // Every write nacked: three attempts on entry 0, then fault.
      log_a.delete();
      rise_a.delete();
      mode = NACK;
      pulse_start(1'b0);
      chk("nack_done_clr", 32'(done_a), 32'd0);
      wait_end("nack_end", 1'b0, 2000);
      chk("nack_nwr",     32'(log_a.size()), 32'd3);
      chk("nack_wr2",     32'((log_a.size() > 2) ? log_a[2] : 16'h0), 32'h1280);
      chk("nack_error",   32'(error_a),   32'd1);
      chk("nack_err_idx", 32'(err_idx_a), 32'd0);
      chk("nack_done",    32'(done_a),    32'd0);

      // Silent engine: each request held 50 cycles, three attempts, fault.
      log_a.delete();
      rise_a.delete();
      mode = SILENT;
      pulse_start(1'b0);
      chk("to_err_clr", 32'(error_a), 32'd0);
      wait_end("to_end", 1'b0, 2000);
      chk("to_nwr",   32'(log_a.size()), 32'd3);
      chk("to_hi",    32'(last_hi_a), 32'd50);
      chk("to_error", 32'(error_a),   32'd1);
      chk("to_busy",  32'(busy_a),    32'd0);

      // Start edge during the inter-write gap is ignored.
      log_a.delete();
      rise_a.delete();
      mode = ACK;
      pulse_start(1'b0);
      wait_req(1'b1, 200);
      wait_req(1'b0, 200);
      start_a = 1'b1;
      repeat (2) @(negedge clk);
      chk("ign_busy", 32'(busy_a), 32'd1);
      start_a = 1'b0;
      wait_end("ign_end", 1'b0, 2000);
      chk("ign_nwr", 32'(log_a.size()), 32'd2);
      chk("ign_wr1", 32'((log_a.size() > 1) ? log_a[1] : 16'h0), 32'h1101);
      chk("ign_done", 32'(done_a), 32'd1);

      // Reset while a write is outstanding, start held high across it.
      log_a.delete();
      rise_a.delete();
      pulse_start(1'b0);
      wait_req(1'b1, 200);
      start_a = 1'b1;
      rst     = 1'b1;
      #1;
      chk("mid_rst_wr_req", 32'(wr_req_a), 32'd0);
      chk("mid_rst_busy",   32'(busy_a),   32'd0);
      @(negedge clk);
      rst = 1'b0;
      log_a.delete();
      rise_a.delete();
      repeat (20) @(negedge clk);
      chk("held_busy", 32'(busy_a), 32'd0);
      chk("held_nwr",  32'(log_a.size()), 32'd0);
      chk("held_done", 32'(done_a), 32'd0);
      start_a = 1'b0;
      pulse_start(1'b0);
      wait_end("restart_end", 1'b0, 2000);
      chk("restart_wr0",  32'((log_a.size() > 0) ? log_a[0] : 16'h0), 32'h1280);
      chk("restart_nwr",  32'(log_a.size()), 32'd2);
      chk("restart_done", 32'(done_a), 32'd1);

      // Table with no end marker: four writes then done, no wrap.
      log_b.delete();
      pulse_start(1'b1);
      wait_end("ne_end", 1'b1, 2000);
      repeat (30) @(negedge clk);
      chk("ne_nwr",   32'(log_b.size()), 32'd4);
      chk("ne_wr0",   32'((log_b.size() > 0) ? log_b[0] : 16'h0), 32'h0111);
      chk("ne_wr3",   32'((log_b.size() > 3) ? log_b[3] : 16'h0), 32'h0444);
      chk("ne_done",  32'(done_b),  32'd1);
      chk("ne_error", 32'(error_b), 32'd0);
      chk("ne_busy",  32'(busy_b),  32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
